// File: rtl/dma_read_master.sv
// Avalon-MM burst read master: reads line_count lines of read_length bytes
// into a show-ahead FIFO. Ports: control_* job setup/status, master_* Avalon
// read command/response, user_* FIFO pop side. Async active-low reset.
`timescale 1ns/1ps
module dma_read_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic                        control_go,
    input  logic                        control_fixed_location,
    input  logic [ADDR_WIDTH-1:0]       control_read_base,
    input  logic [31:0]                 control_read_length,
    input  logic [15:0]                 control_line_count,
    input  logic [ADDR_WIDTH-1:0]       control_line_stride,
    input  logic                        control_abort,
    output logic                        control_busy,
    output logic                        control_early_done,
    output logic                        control_done,
    input  logic                        user_read_buffer,
    output logic [DATA_WIDTH-1:0]       user_buffer_output_data,
    output logic                        user_data_available,
    output logic [ADDR_WIDTH-1:0]       master_address,
    output logic                        master_read,
    output logic [$clog2(MAX_BURST):0]  master_burstcount,
    output logic [DATA_WIDTH/8-1:0]     master_byteenable,
    input  logic [DATA_WIDTH-1:0]       master_readdata,
    input  logic                        master_readdatavalid,
    input  logic                        master_waitrequest
);
    localparam int BPW    = DATA_WIDTH / 8;
    localparam int BPW_SH = $clog2(BPW);
    localparam int BW     = $clog2(MAX_BURST) + 1;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_ABORT} state_t;

    state_t                state_q, state_d;
    logic                  fixed_q, fixed_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] line_start_q, line_start_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           line_words_q, line_words_d;
    logic [31:0]           words_left_q, words_left_d;
    logic [15:0]           lines_left_q, lines_left_d;
    logic                  read_q, read_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [CW-1:0]         out_q, out_d;
    logic                  done_q, done_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic          accept, live, push, pop, flush, rsp;
    logic          end_of_line, last_cmd, credit_ok;
    logic [BW-1:0] burst_next;
    logic [31:0]   req_words;

    assign req_words = control_read_length >> BPW_SH;

    always_comb begin
        state_d      = state_q;
        fixed_d      = fixed_q;
        base_d       = base_q;
        stride_d     = stride_q;
        line_start_d = line_start_q;
        addr_d       = addr_q;
        line_words_d = line_words_q;
        words_left_d = words_left_q;
        lines_left_d = lines_left_q;
        read_d       = read_q;
        burst_d      = burst_q;
        done_d       = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        accept = read_q && !master_waitrequest;
        live   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        push   = master_readdatavalid && live && !control_abort;
        pop    = user_read_buffer && (count_q != '0);
        flush  = (state_q == S_ABORT) || (live && control_abort);
        rsp    = master_readdatavalid && (state_q != S_IDLE);

        end_of_line = (words_left_q == 32'(burst_q));
        last_cmd    = end_of_line && (lines_left_q == 16'd1);

        if (words_left_q >= 32'(MAX_BURST)) burst_next = BW'(MAX_BURST);
        else                                burst_next = words_left_q[BW-1:0];

        // Reserve room for every word already requested, not just stored ones.
        credit_ok = (32'(count_q) + 32'(out_q) + 32'(burst_next))
                    <= 32'(FIFO_DEPTH);

        out_d = out_q + (accept ? CW'(burst_q) : CW'(0))
                      - (rsp ? CW'(1) : CW'(0));

        if (accept) begin
            read_d  = 1'b0;
            burst_d = '0;
            if (end_of_line) begin
                lines_left_d = lines_left_q - 16'd1;
                words_left_d = line_words_q;
                line_start_d = line_start_q + stride_q;
                addr_d = fixed_q ? base_q : line_start_q + stride_q;
            end else begin
                words_left_d = words_left_q - 32'(burst_q);
                addr_d = fixed_q ? base_q
                       : addr_q + (ADDR_WIDTH'(burst_q) << BPW_SH);
            end
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (push ? CW'(1) : CW'(0))
                              - (pop ? CW'(1) : CW'(0));
        end

        unique case (state_q)
            S_IDLE: begin
                if (control_go) begin
                    if (req_words == 32'd0 || control_line_count == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = S_ISSUE;
                        fixed_d      = control_fixed_location;
                        base_d       = control_read_base;
                        stride_d     = control_line_stride;
                        line_start_d = control_read_base;
                        addr_d       = control_read_base;
                        line_words_d = req_words;
                        words_left_d = req_words;
                        lines_left_d = control_line_count;
                    end
                end
            end
            S_ISSUE: begin
                // A stalled read stays up through abort until accepted.
                if (control_abort) begin
                    state_d = S_ABORT;
                end else if (accept && last_cmd) begin
                    state_d = S_DRAIN;
                end else if (!read_q && credit_ok) begin
                    read_d  = 1'b1;
                    burst_d = burst_next;
                end
            end
            S_DRAIN: begin
                if (control_abort) begin
                    state_d = S_ABORT;
                end else if (out_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_ABORT: begin
                if (!read_q && out_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= S_IDLE;
            fixed_q      <= 1'b0;
            base_q       <= '0;
            stride_q     <= '0;
            line_start_q <= '0;
            addr_q       <= '0;
            line_words_q <= '0;
            words_left_q <= '0;
            lines_left_q <= '0;
            read_q       <= 1'b0;
            burst_q      <= '0;
            out_q        <= '0;
            done_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fixed_q      <= fixed_d;
            base_q       <= base_d;
            stride_q     <= stride_d;
            line_start_q <= line_start_d;
            addr_q       <= addr_d;
            line_words_q <= line_words_d;
            words_left_q <= words_left_d;
            lines_left_q <= lines_left_d;
            read_q       <= read_d;
            burst_q      <= burst_d;
            out_q        <= out_d;
            done_q       <= done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) mem_q[wr_ptr_q] <= master_readdata;
    end

    assign control_busy            = (state_q != S_IDLE);
    assign control_early_done      = (state_q == S_DRAIN) && (out_q != '0);
    assign control_done            = done_q;
    assign user_buffer_output_data = mem_q[rd_ptr_q];
    assign user_data_available     = (count_q != '0);
    assign master_address          = addr_q;
    assign master_read             = read_q;
    assign master_burstcount       = burst_q;
    assign master_byteenable       = '1;

endmodule

// File: tb/tb_dma_read_master.sv
// Directed bench for dma_read_master: behavioural Avalon slave returning
// data equal to the word address, plus a FIFO consumer and job checks.
`timescale 1ns/1ps
module tb_dma_read_master;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MB = 8;
    localparam int FD = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b1;
    logic          control_go = 1'b0;
    logic          control_fixed_location = 1'b0;
    logic [AW-1:0] control_read_base = '0;
    logic [31:0]   control_read_length = '0;
    logic [15:0]   control_line_count = '0;
    logic [AW-1:0] control_line_stride = '0;
    logic          control_abort = 1'b0;
    logic          control_busy, control_early_done, control_done;
    logic          user_read_buffer = 1'b0;
    logic [DW-1:0] user_buffer_output_data;
    logic          user_data_available;
    logic [AW-1:0] master_address;
    logic          master_read;
    logic [3:0]    master_burstcount;
    logic [3:0]    master_byteenable;
    logic [DW-1:0] master_readdata = '0;
    logic          master_readdatavalid = 1'b0;
    logic          master_waitrequest = 1'b0;

    dma_read_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB), .FIFO_DEPTH(FD)
    ) dut (
        .clk_clk                (clk),
        .reset_reset_n          (rst_n),
        .control_go             (control_go),
        .control_fixed_location (control_fixed_location),
        .control_read_base      (control_read_base),
        .control_read_length    (control_read_length),
        .control_line_count     (control_line_count),
        .control_line_stride    (control_line_stride),
        .control_abort          (control_abort),
        .control_busy           (control_busy),
        .control_early_done     (control_early_done),
        .control_done           (control_done),
        .user_read_buffer       (user_read_buffer),
        .user_buffer_output_data(user_buffer_output_data),
        .user_data_available    (user_data_available),
        .master_address         (master_address),
        .master_read            (master_read),
        .master_burstcount      (master_burstcount),
        .master_byteenable      (master_byteenable),
        .master_readdata        (master_readdata),
        .master_readdatavalid   (master_readdatavalid),
        .master_waitrequest     (master_waitrequest)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] cmd_addr [$];
    int          cmd_burst [$];
    logic [31:0] pend [$];
    logic [31:0] rx [$];

    bit resp_en = 1'b1;
    bit pop_en = 1'b1;
    bit wr_hold = 1'b0;
    int stall_at = 0;
    int clr_tok = 0;
    int clr_seen = 0;
    int acc_words = 0;
    int pop_words = 0;
    int max_occ = 0;
    int done_cnt = 0;
    bit early_seen = 1'b0;
    bit read_seen = 1'b0;

    // Slave and consumer act on the falling edge so the DUT sees stable
    // inputs at the rising edge.
    always @(negedge clk) begin
        if (clr_tok != clr_seen) begin
            cmd_addr.delete();
            cmd_burst.delete();
            pend.delete();
            rx.delete();
            acc_words  = 0;
            pop_words  = 0;
            max_occ    = 0;
            early_seen = 1'b0;
            read_seen  = 1'b0;
            clr_seen   = clr_tok;
        end
        if (resp_en && pend.size() > 0) begin
            master_readdatavalid = 1'b1;
            master_readdata      = pend.pop_front();
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = '0;
        end
        master_waitrequest = wr_hold ||
            (stall_at != 0 && cmd_addr.size() >= stall_at);
        if (master_read && !master_waitrequest) begin
            cmd_addr.push_back(master_address);
            cmd_burst.push_back(int'(master_burstcount));
            for (int i = 0; i < int'(master_burstcount); i++)
                pend.push_back(master_address + 32'(4 * i));
            acc_words += int'(master_burstcount);
        end
        if (pop_en && user_data_available) begin
            rx.push_back(user_buffer_output_data);
            user_read_buffer = 1'b1;
            pop_words++;
        end else begin
            user_read_buffer = 1'b0;
        end
        if (acc_words - pop_words > max_occ) max_occ = acc_words - pop_words;
        if (control_done) done_cnt++;
        if (control_early_done) early_seen = 1'b1;
        if (master_read) read_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        clr_tok++;
        tick(1);
    endtask

    task automatic start_job(input logic [31:0] base, input logic [31:0] len,
                             input logic [15:0] lines, input logic [31:0] stride,
                             input logic fixed);
        control_read_base      = base;
        control_read_length    = len;
        control_line_count     = lines;
        control_line_stride    = stride;
        control_fixed_location = fixed;
        control_go = 1'b1;
        tick(1);
        control_go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0;
        int k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, 64'(done_cnt != n0), 64'd1);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int k;

        // Reset state
        #2 rst_n = 1'b0;
        tick(3);
        chk("rst_read",  master_read, 0);
        chk("rst_busy",  control_busy, 0);
        chk("rst_done",  control_done, 0);
        chk("rst_early", control_early_done, 0);
        chk("rst_avail", user_data_available, 0);
        chk("rst_bc",    master_burstcount, 0);
        chk("rst_addr",  master_address, 0);
        rst_n = 1'b1;
        tick(2);

        // Single line of 16 words, zero-wait slave
        clear_logs();
        n0 = done_cnt;
        start_job(32'h1000, 64, 1, 0, 1'b0);
        chk("t1_busy", control_busy, 1);
        wait_done("t1_done", 300);
        tick(6);
        chk("t1_donecnt", done_cnt, n0 + 1);
        chk("t1_busy_end", control_busy, 0);
        chk("t1_early", early_seen, 1);
        chk("t1_ncmd", cmd_addr.size(), 2);
        chk("t1_a0", cmd_addr[0], 32'h1000);
        chk("t1_b0", cmd_burst[0], 8);
        chk("t1_a1", cmd_addr[1], 32'h1020);
        chk("t1_b1", cmd_burst[1], 8);
        chk("t1_nrx", rx.size(), 16);
        for (int i = 0; i < 16; i++)
            chk("t1_word", rx[i], 32'h1000 + 4 * i);

        // Three lines of 10 words with stride
        clear_logs();
        start_job(32'h0, 40, 3, 32'h100, 1'b0);
        wait_done("t2_done", 400);
        tick(6);
        chk("t2_ncmd", cmd_addr.size(), 6);
        for (int l = 0; l < 3; l++) begin
            chk("t2_aA", cmd_addr[2 * l], 32'h100 * l);
            chk("t2_bA", cmd_burst[2 * l], 8);
            chk("t2_aB", cmd_addr[2 * l + 1], 32'h100 * l + 32'h20);
            chk("t2_bB", cmd_burst[2 * l + 1], 2);
        end
        chk("t2_nrx", rx.size(), 30);
        for (int l = 0; l < 3; l++)
            for (int i = 0; i < 10; i++)
                chk("t2_word", rx[10 * l + i], 32'h100 * l + 4 * i);

        // Credit back-pressure: consumer stalled, FIFO of 16
        clear_logs();
        pop_en = 1'b0;
        start_job(32'h4000, 256, 1, 0, 1'b0);
        tick(50);
        control_read_base = 32'h7000;
        control_go = 1'b1;
        tick(1);
        control_go = 1'b0;
        tick(50);
        chk("t3_acc_stall", acc_words, 16);
        chk("t3_avail", user_data_available, 1);
        chk("t3_busy", control_busy, 1);
        chk("t3_early_stall", control_early_done, 0);
        pop_en = 1'b1;
        wait_done("t3_done", 1500);
        tick(6);
        chk("t3_occ", 64'(max_occ <= FD), 1);
        chk("t3_ncmd", cmd_addr.size(), 8);
        for (int j = 0; j < 8; j++)
            chk("t3_addr", cmd_addr[j], 32'h4000 + 32 * j);
        chk("t3_nrx", rx.size(), 64);
        for (int i = 0; i < 64; i++)
            chk("t3_word", rx[i], 32'h4000 + 4 * i);

        // Fixed location
        clear_logs();
        start_job(32'h2000, 32, 2, 32'h100, 1'b1);
        wait_done("t4_done", 400);
        tick(6);
        chk("t4_ncmd", cmd_addr.size(), 2);
        chk("t4_a0", cmd_addr[0], 32'h2000);
        chk("t4_a1", cmd_addr[1], 32'h2000);
        chk("t4_nrx", rx.size(), 16);
        for (int i = 0; i < 16; i++)
            chk("t4_word", rx[i], 32'h2000 + 4 * (i % 8));

        // Abort with a stalled command and 12 words outstanding
        clear_logs();
        pop_en = 1'b0;
        resp_en = 1'b0;
        stall_at = 3;
        n0 = done_cnt;
        start_job(32'h8000, 16, 4, 32'h40, 1'b0);
        k = 0;
        while (!(cmd_addr.size() == 3 && master_read) && k < 200) begin
            tick(1);
            k++;
        end
        chk("t5_reach_stall", 64'(k < 200), 1);
        tick(3);
        chk("t5_held_read", master_read, 1);
        chk("t5_held_addr", master_address, 32'h80C0);
        chk("t5_held_bc", master_burstcount, 4);
        control_abort = 1'b1;
        tick(1);
        control_abort = 1'b0;
        chk("t5_ab_busy", control_busy, 1);
        chk("t5_ab_early", control_early_done, 0);
        chk("t5_ab_read", master_read, 1);
        chk("t5_ab_addr", master_address, 32'h80C0);
        tick(2);
        chk("t5_ab_read2", master_read, 1);
        stall_at = 0;
        tick(3);
        chk("t5_ncmd", cmd_addr.size(), 4);
        chk("t5_read_off", master_read, 0);
        tick(20);
        chk("t5_ncmd_late", cmd_addr.size(), 4);
        chk("t5_busy_wait", control_busy, 1);
        chk("t5_nodone", done_cnt, n0);
        resp_en = 1'b1;
        wait_done("t5_done", 200);
        tick(4);
        chk("t5_donecnt", done_cnt, n0 + 1);
        chk("t5_avail", user_data_available, 0);
        chk("t5_busy_end", control_busy, 0);
        chk("t5_early", early_seen, 0);
        pop_en = 1'b1;

        // Zero-length and zero-line jobs
        clear_logs();
        n0 = done_cnt;
        start_job(32'h3000, 0, 5, 0, 1'b0);
        chk("t6_done", control_done, 1);
        chk("t6_busy", control_busy, 0);
        tick(1);
        chk("t6_done_low", control_done, 0);
        start_job(32'h3000, 64, 0, 0, 1'b0);
        chk("t6_done_l0", control_done, 1);
        tick(3);
        chk("t6_donecnt", done_cnt, n0 + 2);
        chk("t6_noread", read_seen, 0);

        // Abort in IDLE is ignored
        n0 = done_cnt;
        control_abort = 1'b1;
        tick(1);
        control_abort = 1'b0;
        tick(2);
        chk("t7_busy", control_busy, 0);
        chk("t7_nodone", done_cnt, n0);

        // Reset mid-job; late responses ignored
        clear_logs();
        resp_en = 1'b0;
        pop_en = 1'b0;
        n0 = done_cnt;
        start_job(32'hA000, 32, 1, 0, 1'b0);
        k = 0;
        while (cmd_addr.size() < 1 && k < 100) begin
            tick(1);
            k++;
        end
        chk("t8_cmd", cmd_addr.size(), 1);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("t8_rst_busy", control_busy, 0);
        chk("t8_rst_read", master_read, 0);
        chk("t8_rst_addr", master_address, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        resp_en = 1'b1;
        tick(20);
        chk("t8_avail", user_data_available, 0);
        chk("t8_busy", control_busy, 0);
        chk("t8_nodone", done_cnt, n0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dma_read_master.md
DMA_READ_MASTER -- requirements
Module: dma_read_master

Interface
REQ-001 DATA_WIDTH, 32, Avalon read data width in bits; SHALL be 32, 64 or 128.
REQ-002 ADDR_WIDTH, 32, byte address width.
REQ-003 MAX_BURST, 8, maximum burstcount; SHALL be a power of 2 from 1 to 64.
REQ-004 FIFO_DEPTH, 64, buffer words; SHALL be a power of 2 and at least 2*MAX_BURST.
REQ-005 clk_clk  in  1  sole clock; all logic is rising-edge.
REQ-006 reset_reset_n  in  1  asynchronous active-low reset.
REQ-007 control_go  in  1  start pulse; sampled only in IDLE.
REQ-008 control_fixed_location  in  1  reread the same address for the whole job.
REQ-009 control_read_base  in  ADDR_WIDTH  first line byte address.
REQ-010 control_read_length  in  32  bytes per line.
REQ-011 control_line_count  in  16  lines per job.
REQ-012 control_line_stride  in  ADDR_WIDTH  byte offset between line starts.
REQ-013 control_abort  in  1  cancel the current job.
REQ-014 control_busy  out  1  job in progress.
REQ-015 control_early_done  out  1  all commands issued, with data still outstanding.
REQ-016 control_done  out  1  one-cycle job-complete pulse.
REQ-017 user_read_buffer  in  1  pop the FIFO head.
REQ-018 user_buffer_output_data  out  DATA_WIDTH  FIFO head (show-ahead).
REQ-019 user_data_available  out  1  FIFO not empty.
REQ-020 master_address, master_read, master_burstcount, master_byteenable  out  ADDR_WIDTH, 1, log2(MAX_BURST)+1, DATA_WIDTH/8  Avalon-MM read command.
REQ-021 master_readdata, master_readdatavalid, master_waitrequest  in  DATA_WIDTH, 1, 1  Avalon-MM response and stall.

Function
REQ-022 Word size: BPW = DATA_WIDTH/8; read_length and stride SHALL be multiples of BPW, and read_base SHALL be BPW-aligned; master_byteenable SHALL be all ones.
REQ-023 State machine:
- IDLE -> ISSUE on go when read_length != 0 and line_count != 0; go SHALL latch all control inputs.
- go with zero length or zero line_count: done pulses the next cycle, no bus traffic, stays IDLE.
REQ-024 ISSUE:
- Burst = min(MAX_BURST, words left in the current line); bursts SHALL never span lines.
- A burst SHALL be issued only when FIFO_DEPTH - fill - outstanding >= burst.
REQ-025 While master_waitrequest=1, master_read, master_address and master_burstcount SHALL hold stable.
REQ-026 Command acceptance (read=1 and waitrequest=0):
- outstanding += burst.
- Address += burst*BPW.
- At end of line: line_start += stride and address = line_start.
- With fixed_location=1, address SHALL stay read_base throughout.
REQ-027 Each readdatavalid SHALL push readdata into the FIFO and decrement outstanding; push and pop in the same cycle SHALL leave fill unchanged.
REQ-028 After the last command is accepted: ISSUE -> DRAIN; early_done SHALL be 1 in DRAIN while outstanding > 0.
REQ-029 DRAIN -> IDLE when outstanding = 0: done pulses for 1 cycle, busy falls the same cycle, and FIFO contents remain readable.
REQ-030 Pop when the FIFO is empty SHALL be ignored; the FIFO SHALL never overflow (guaranteed by the credit rule in REQ-024).
REQ-031 Abort in ISSUE or DRAIN:
- An in-flight stalled command completes acceptance; no further commands are issued.
- State -> ABORT, the FIFO is flushed, and readdatavalid words are discarded.
- ABORT -> IDLE when outstanding = 0, with a done pulse.
- early_done SHALL be 0 in ABORT.
REQ-032 Abort in IDLE SHALL be ignored; go outside IDLE SHALL be ignored.
REQ-033 busy = 1 in ISSUE, DRAIN and ABORT.

Reset
REQ-034 On reset_reset_n=0, asynchronously: state IDLE; read, busy, done, early_done, data_available = 0; burstcount = 0; address = 0; FIFO empty; outstanding = 0.
REQ-035 Reset mid-job SHALL drop all outstanding responses; readdatavalid arriving after reset release while in IDLE SHALL be ignored.

Verification
REQ-036 DATA_WIDTH=32; base 0x1000, length 64, lines 1; zero-wait slave -> bursts 8 @0x1000 and 8 @0x1020, 16 words in order, early_done then a done pulse.
REQ-037 length 40, lines 3, stride 0x100, base 0 -> bursts (8,2) at 0x000/0x020, 0x100/0x120, 0x200/0x220; 30 words total.
REQ-038 FIFO_DEPTH=16, user never pops, length 256 -> commands stall with fill+outstanding <= 16; popping resumes issue; no word lost.
REQ-039 fixed_location=1, length 32, lines 2 -> every command at base address; 16 words.
REQ-040 Abort while waitrequest=1 and 12 words outstanding -> command held until accepted, then no new read; data discarded; done once outstanding = 0; data_available = 0.
REQ-041 go with length 0 -> done one cycle later; master_read never asserted.
